// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions used by both the serial encoder and decoder.
// Contents:
//   - code-position constants (positions 1..7 map to code[0..6])
//   - parity-check masks for s1, s2 and s4
//   - decoder FSM state encoding
//   - syndrome(code) -> {s4,s2,s1}
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;

  // Bit index inside code[6:0] for each Hamming position.
  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_D0 = 2;
  localparam int POS_P4 = 3;
  localparam int POS_D1 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;

  // Each mask selects the code bits covered by one parity check.
  localparam logic [CODE_W-1:0] MASK_S1 = 7'b1010101;
  localparam logic [CODE_W-1:0] MASK_S2 = 7'b1100110;
  localparam logic [CODE_W-1:0] MASK_S4 = 7'b1111000;

  typedef enum logic {
    S_SHIFT  = 1'b0,
    S_DECODE = 1'b1
  } state_t;

  // Nonzero result is the 1-based position of a single flipped bit.
  function automatic logic [2:0] syndrome(input logic [CODE_W-1:0] code);
    return {^(code & MASK_S4), ^(code & MASK_S2), ^(code & MASK_S1)};
  endfunction

endpackage

// File: rtl/hamming_corrector.sv
// Combinational Hamming(7,4) single-error corrector.
// Ports:
//   code      in  7  received codeword, code[0] = position 1
//   data      out 4  corrected data {d3,d2,d1,d0}
//   corrected out 1  syndrome was nonzero and one bit was inverted
// Double errors are miscorrected silently; no detection is attempted.
module hamming_corrector
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic              corrected
);

  logic [2:0]        syn;
  logic [CODE_W-1:0] fixed;

  assign syn = syndrome(code);

  // Flip the one bit whose 1-based position equals the syndrome.
  genvar gi;
  for (gi = 0; gi < CODE_W; gi++) begin : g_fix
    assign fixed[gi] = code[gi] ^ (syn == 3'(gi + 1));
  end

  assign data      = {fixed[POS_D3], fixed[POS_D2], fixed[POS_D1], fixed[POS_D0]};
  assign corrected = |syn;

endmodule

// File: rtl/hamming_serial_decoder.sv
// Bit-serial Hamming(7,4) decoder: assembles 7-bit frames (code[0] first),
// corrects single-bit errors and presents 4-bit words on a valid/ready port.
// Partial frames that stall for TIMEOUT_CYCLES idle cycles are discarded.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   serial_in/valid/ready        bit-serial input handshake
//   data_out/valid/ready         corrected word output handshake (held until taken)
//   corrected                    word on data_out had a nonzero syndrome
//   frame_dropped                one-cycle pulse when a partial frame times out
//   error_count                  saturating count of corrected words
// Build option: define HAMMING_ERRCNT_EN to implement error_count; otherwise it is tied to 0.
module hamming_serial_decoder
  import hamming_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic                 serial_valid,
  output logic                 serial_ready,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 corrected,
  output logic                 frame_dropped,
  output logic [ERR_CNT_W-1:0] error_count
);

  // Idle counter only needs to count up to TIMEOUT_CYCLES-1; the next idle cycle drops.
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t              state_reg;
  logic [2:0]          cnt_reg;
  logic [CODE_W-1:0]   shift_reg;
  logic [IDLE_W-1:0]   idle_reg;
  logic [DATA_W-1:0]   data_out_reg;
  logic                data_valid_reg;
  logic                corrected_reg;
  logic                frame_dropped_reg;

  logic [DATA_W-1:0]   fix_data;
  logic                fix_corr;
  logic                accept;
  logic                take;
  logic                load;

  hamming_corrector u_corrector (
    .code      (shift_reg),
    .data      (fix_data),
    .corrected (fix_corr)
  );

  assign serial_ready = (state_reg == S_SHIFT);
  assign accept       = serial_valid & serial_ready;
  assign take         = data_valid_reg & data_ready;
  // The slot is free when empty or being emptied this very cycle.
  assign load         = (state_reg == S_DECODE) & (~data_valid_reg | data_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= S_SHIFT;
      cnt_reg           <= '0;
      shift_reg         <= '0;
      idle_reg          <= '0;
      data_out_reg      <= '0;
      data_valid_reg    <= 1'b0;
      corrected_reg     <= 1'b0;
      frame_dropped_reg <= 1'b0;
    end else begin
      frame_dropped_reg <= 1'b0;

      if (load) begin
        data_out_reg   <= fix_data;
        corrected_reg  <= fix_corr;
        data_valid_reg <= 1'b1;
      end else if (take) begin
        data_valid_reg <= 1'b0;
      end

      case (state_reg)
        S_SHIFT: begin
          if (accept) begin
            shift_reg[cnt_reg] <= serial_in;
            cnt_reg            <= cnt_reg + 3'd1;
            idle_reg           <= '0;
            if (cnt_reg == 3'd6) begin
              state_reg <= S_DECODE;
            end
          end else if (TIMEOUT_CYCLES != 0 && cnt_reg != 3'd0) begin
            // Stall mid-frame: count idle cycles and drop the partial frame on expiry.
            if (idle_reg == IDLE_LAST) begin
              cnt_reg           <= '0;
              idle_reg          <= '0;
              frame_dropped_reg <= 1'b1;
            end else begin
              idle_reg <= idle_reg + 1'b1;
            end
          end
        end
        S_DECODE: begin
          if (load) begin
            cnt_reg   <= '0;
            state_reg <= S_SHIFT;
          end
        end
        default: state_reg <= S_SHIFT;
      endcase
    end
  end

  assign data_out      = data_out_reg;
  assign data_valid    = data_valid_reg;
  assign corrected     = corrected_reg;
  assign frame_dropped = frame_dropped_reg;

`ifdef HAMMING_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_cnt_reg <= '0;
    end else if (load && fix_corr && err_cnt_reg != '1) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign error_count = err_cnt_reg;
`else
  assign error_count = '0;
`endif

endmodule
